vp_mem_bridge: RTL and testbench
================================

VP_MEM_BRIDGE -- requirements
Module: vp_mem_bridge

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, the number of extra wait cycles (0-15) before each memory access.
REQ-002 SHALL have parameter SEG, default 4'ha, the address segment (Addr[31:28]) decoded as memory.
REQ-003 SHALL have parameter MEM_AW, default 10, the memory word-address width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1 is the rising-edge clock, and reset input 1 is the asynchronous active-high reset.
REQ-005 SHALL have ports:
- addr input 32: VProc address.
- we input 1: VProc write strobe.
- rd input 1: VProc read strobe.
- data_out input 32: VProc write data.
- data_in output 32: VProc read data.
- wr_ack output 1: write acknowledge.
- rd_ack output 1: read acknowledge.
- mem_addr output MEM_AW: SRAM address.
- mem_wdata output 32: SRAM write data.
- mem_en output 1: SRAM enable.
- mem_we output 1: SRAM write enable.
- mem_rdata input 32: SRAM read data, valid one cycle after mem_en.
- rd_count output 16: completed reads.
- wr_count output 16: completed writes.

Function
REQ-006 SHALL implement the states IDLE, WAIT, ACCESS, ACK and RECOVER.
REQ-007 SHALL leave IDLE when we or rd is sampled high at a clk edge: it goes to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-008 SHALL register addr, data_out and the access type on leaving IDLE; strobe changes after that point are ignored until the return to IDLE.
REQ-009 SHALL treat we and rd high together as a write only, and never assert rd_ack for it.
REQ-010 SHALL stay in WAIT for exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to ACCESS.
REQ-011 SHALL, in ACCESS (one cycle), assert mem_en and drive mem_addr=addr[MEM_AW-1:0] and mem_wdata=data_out; mem_we=1 only for a write.
REQ-012 SHALL, in ACK (one cycle), assert exactly one of wr_ack or rd_ack.
REQ-013 SHALL drive data_in=mem_rdata during ACK for a read.
REQ-014 SHALL hold data_in at the last ACK value outside ACK, in a hold register.
REQ-015 SHALL spend exactly one cycle in RECOVER, ignoring strobes, then return to IDLE.
REQ-016 SHALL make the latency from the strobe-sampling edge to the ack cycle WAIT_STATES+2 cycles, giving a throughput of one access per WAIT_STATES+4 cycles.
REQ-017 SHALL, for an access with addr[31:28]!=SEG, run the same state sequence with mem_en=0 and mem_we=0, and ack a read with data_in=32'h0.
REQ-018 SHALL increment rd_count/wr_count on each ack, saturating at 16'hffff with no wrap.

Reset
REQ-019 SHALL make reset asynchronous: state goes to IDLE, and wr_ack, rd_ack, mem_en, mem_we=0, data_in=0, mem_addr=0, mem_wdata=0, counters=0, wait counter=0.
REQ-020 SHALL abandon any access in progress when reset is asserted, with no ack, no mem_we and no count.
REQ-021 SHALL sample strobes again only at the first clk edge after reset deasserts.

Configuration
REQ-022 SHALL, with VP_MEM_BRIDGE_ERR_EN defined, ack an out-of-segment read with data_in=32'hdeadbeef.
REQ-023 SHALL, with VP_MEM_BRIDGE_ERR_EN defined, add output err_irq (1 bit), pulsed high for the ACK cycle of any out-of-segment access.
REQ-024 SHALL, without VP_MEM_BRIDGE_ERR_EN, behave as REQ-017 and have no err_irq port.

Structure
REQ-025 SHALL place the state enumeration, the segment default constant and the 32'hdeadbeef error constant in shared package vp_mem_bridge_pkg.
REQ-026 SHALL place the 16-bit saturating counter in sub-module vp_sat_counter, instantiated twice.

Verification
REQ-027 SHALL cover write then read: WAIT_STATES=2, write addr=32'ha000_0010, data=32'h1234_5678 → mem_we pulse with mem_addr=10'h010; wr_ack 4 cycles after the strobe edge; a read of the same address gives rd_ack with data_in=32'h1234_5678; wr_count=1, rd_count=1.
REQ-028 SHALL cover zero wait: WAIT_STATES=0 → the ack arrives 2 cycles after the strobe and back-to-back reads complete every 4 cycles.
REQ-029 SHALL cover out-of-segment access: read addr=32'h5000_0000 → no mem_en; data_in=0, or 32'hdeadbeef with an err_irq pulse when VP_MEM_BRIDGE_ERR_EN is defined.
REQ-030 SHALL cover simultaneous strobes: we=rd=1 → write performed, wr_ack only, rd_count unchanged.
REQ-031 SHALL cover reset mid-access: reset asserted during WAIT → no ack, no mem_we, counters 0; after release, a new read completes normally.
REQ-032 SHALL cover saturation: 65537 writes → wr_count=16'hffff.

Source files
------------

// File: rtl/vp_mem_bridge_pkg.sv
// vp_mem_bridge_pkg: shared types and constants for the VProc memory bridge.
package vp_mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  // Address segment (addr[31:28]) that maps onto the SRAM
  localparam logic [3:0]  SEG_DEFAULT = 4'ha;

  // Read data returned for out-of-segment reads when error reporting is built in
  localparam logic [31:0] ERR_DATA    = 32'hdead_beef;

  // True when the top address nibble selects the memory segment
  function automatic logic seg_hit(input logic [3:0] nib, input logic [3:0] seg);
    return (nib == seg);
  endfunction

endpackage

// File: rtl/vp_sat_counter.sv
// vp_sat_counter: event counter that sticks at all-ones instead of wrapping.
module vp_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Count one per inc pulse, holding once the maximum is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (inc && (count_r != MAX_VAL)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/vp_mem_bridge.sv
// vp_mem_bridge: bridges VProc read/write strobes onto a synchronous SRAM with
// programmable wait states. Each access runs IDLE -> [WAIT] -> ACCESS -> ACK -> RECOVER.
// Optional build macro VP_MEM_BRIDGE_ERR_EN: out-of-segment reads return 32'hdeadbeef
// and an err_irq output pulses during the ACK cycle of any out-of-segment access.
module vp_mem_bridge
  import vp_mem_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [3:0]  SEG         = SEG_DEFAULT,
  parameter int unsigned MEM_AW      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic              rd,
  input  logic [31:0]       data_out,
  output logic [31:0]       data_in,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
`ifdef VP_MEM_BRIDGE_ERR_EN
  output logic              err_irq,
`endif
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef VP_MEM_BRIDGE_ERR_EN
  localparam logic [31:0] OOS_RDATA = ERR_DATA;
`else
  localparam logic [31:0] OOS_RDATA = 32'h0000_0000;
`endif

  state_e            state_r;
  logic [3:0]        wait_cnt_r;
  logic [MEM_AW-1:0] acc_addr_r;
  logic [31:0]       acc_wdata_r;
  logic              acc_wr_r;
  logic              acc_hit_r;
  logic              wr_ack_r;
  logic              rd_ack_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [MEM_AW-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [31:0]       hold_r;
`ifdef VP_MEM_BRIDGE_ERR_EN
  logic              err_irq_r;
`endif

  logic              start_s;
  logic              go_access_s;
  logic [MEM_AW-1:0] cur_addr_s;
  logic [31:0]       cur_wdata_s;
  logic              cur_wr_s;
  logic              cur_hit_s;
  logic [31:0]       rd_data_s;
  logic [31:0]       data_in_s;
  logic              unused_addr_s;

  // Address bits between the segment nibble and the word address are not decoded
  assign unused_addr_s = ^addr[27:MEM_AW];

  // Use the live request on the capture edge, the captured one afterwards; flag the ACCESS entry
  always_comb begin
    start_s = (state_r == ST_IDLE) && (we || rd);
    if (start_s) begin
      cur_addr_s  = addr[MEM_AW-1:0];
      cur_wdata_s = data_out;
      cur_wr_s    = we;
      cur_hit_s   = seg_hit(addr[31:28], SEG);
    end else begin
      cur_addr_s  = acc_addr_r;
      cur_wdata_s = acc_wdata_r;
      cur_wr_s    = acc_wr_r;
      cur_hit_s   = acc_hit_r;
    end
    if (state_r == ST_IDLE) begin
      go_access_s = start_s && (WS == 4'd0);
    end else if (state_r == ST_WAIT) begin
      go_access_s = (wait_cnt_r == 4'd1);
    end else begin
      go_access_s = 1'b0;
    end
  end

  // Read data: SRAM (or the out-of-segment value) during a read ACK, else the held value
  always_comb begin
    if (acc_hit_r) begin
      rd_data_s = mem_rdata;
    end else begin
      rd_data_s = OOS_RDATA;
    end
    if (rd_ack_r) begin
      data_in_s = rd_data_s;
    end else begin
      data_in_s = hold_r;
    end
  end

  // Access sequencer with registered SRAM controls and acknowledges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 4'd0;
      acc_addr_r  <= '0;
      acc_wdata_r <= 32'h0000_0000;
      acc_wr_r    <= 1'b0;
      acc_hit_r   <= 1'b0;
      wr_ack_r    <= 1'b0;
      rd_ack_r    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      hold_r      <= 32'h0000_0000;
`ifdef VP_MEM_BRIDGE_ERR_EN
      err_irq_r   <= 1'b0;
`endif
    end else begin
      wr_ack_r <= 1'b0;
      rd_ack_r <= 1'b0;
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
`ifdef VP_MEM_BRIDGE_ERR_EN
      err_irq_r <= 1'b0;
`endif
      if (start_s) begin
        acc_addr_r  <= cur_addr_s;
        acc_wdata_r <= cur_wdata_s;
        acc_wr_r    <= cur_wr_s;
        acc_hit_r   <= cur_hit_s;
      end
      if (go_access_s) begin
        mem_en_r    <= cur_hit_s;
        mem_we_r    <= cur_hit_s && cur_wr_s;
        mem_addr_r  <= cur_addr_s;
        mem_wdata_r <= cur_wdata_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s && (WS != 4'd0)) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= WS;
          end else if (start_s) begin
            state_r <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (go_access_s) begin
            state_r    <= ST_ACCESS;
            wait_cnt_r <= 4'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_ACCESS: begin
          state_r  <= ST_ACK;
          wr_ack_r <= acc_wr_r;
          rd_ack_r <= !acc_wr_r;
`ifdef VP_MEM_BRIDGE_ERR_EN
          err_irq_r <= !acc_hit_r;
`endif
        end
        ST_ACK: begin
          state_r <= ST_RECOVER;
          if (rd_ack_r) begin
            hold_r <= rd_data_s;
          end else begin
            hold_r <= hold_r;
          end
        end
        ST_RECOVER: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  vp_sat_counter #(.WIDTH(16)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_ack_r),
    .count (rd_count)
  );

  vp_sat_counter #(.WIDTH(16)) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_ack_r),
    .count (wr_count)
  );

  assign data_in   = data_in_s;
  assign wr_ack    = wr_ack_r;
  assign rd_ack    = rd_ack_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
`ifdef VP_MEM_BRIDGE_ERR_EN
  assign err_irq   = err_irq_r;
`endif

endmodule

// File: tb/tb_vp_mem_bridge.sv
// tb_vp_mem_bridge: table-driven scoreboard bench for vp_mem_bridge (WAIT_STATES=2 and 0)
// plus a standalone saturation run of vp_sat_counter.
module tb_vp_mem_bridge;

  localparam int A_WS = 2;

`ifdef VP_MEM_BRIDGE_ERR_EN
  localparam logic [31:0] OOS_EXP = 32'hdead_beef;
`else
  localparam logic [31:0] OOS_EXP = 32'h0000_0000;
`endif

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_wr;
    logic        exp_en;
    logic [9:0]  exp_maddr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
    logic        err;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A (WAIT_STATES=2)
  logic [31:0] a_addr = 32'h0, a_wdata = 32'h0, a_data_in, a_mem_wdata, a_mem_rdata;
  logic        a_we = 1'b0, a_rd = 1'b0, a_wr_ack, a_rd_ack, a_mem_en, a_mem_we;
  logic [9:0]  a_mem_addr;
  logic [15:0] a_rd_count, a_wr_count;
  // Instance B (WAIT_STATES=0)
  logic [31:0] b_addr = 32'h0, b_wdata = 32'h0, b_data_in, b_mem_wdata, b_mem_rdata;
  logic        b_we = 1'b0, b_rd = 1'b0, b_wr_ack, b_rd_ack, b_mem_en, b_mem_we;
  logic [9:0]  b_mem_addr;
  logic [15:0] b_rd_count, b_wr_count;
`ifdef VP_MEM_BRIDGE_ERR_EN
  logic a_err_irq, b_err_irq;
`endif
  // Standalone counter
  logic        c_inc = 1'b0;
  logic [15:0] c_count;

  vp_mem_bridge #(.WAIT_STATES(A_WS), .SEG(4'ha), .MEM_AW(10)) dut_a (
    .clk(clk), .reset(reset), .addr(a_addr), .we(a_we), .rd(a_rd), .data_out(a_wdata),
    .data_in(a_data_in), .wr_ack(a_wr_ack), .rd_ack(a_rd_ack), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_rdata(a_mem_rdata),
`ifdef VP_MEM_BRIDGE_ERR_EN
    .err_irq(a_err_irq),
`endif
    .rd_count(a_rd_count), .wr_count(a_wr_count)
  );

  vp_mem_bridge #(.WAIT_STATES(0), .SEG(4'ha), .MEM_AW(10)) dut_b (
    .clk(clk), .reset(reset), .addr(b_addr), .we(b_we), .rd(b_rd), .data_out(b_wdata),
    .data_in(b_data_in), .wr_ack(b_wr_ack), .rd_ack(b_rd_ack), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata),
`ifdef VP_MEM_BRIDGE_ERR_EN
    .err_irq(b_err_irq),
`endif
    .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  vp_sat_counter #(.WIDTH(16)) dut_c (.clk(clk), .reset(reset), .inc(c_inc), .count(c_count));

  // SRAM models: A is a real memory, B returns an address-derived pattern
  logic [31:0] a_sram [0:1023];
  initial for (int i = 0; i < 1024; i++) a_sram[i] = 32'h0;
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) a_sram[a_mem_addr] <= a_mem_wdata;
      a_mem_rdata <= a_sram[a_mem_addr];
    end
    if (b_mem_en) b_mem_rdata <= {22'h0, b_mem_addr} ^ 32'h5a5a_0000;
  end

  // Activity monitors for the abort sequence
  int we_pulses = 0;
  int acks_seen = 0;
  always @(posedge clk) begin
    if (a_mem_we) we_pulses <= we_pulses + 1;
    if (a_wr_ack || a_rd_ack) acks_seen <= acks_seen + 1;
  end

  int n_pass = 0;
  int n_total = 0;
  sb_t sb[$];
  vec_t vecs[9];
  int exp_wr_cnt = 0;
  int exp_rd_cnt = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // One access on instance A, checked cycle by cycle against the vector
  task automatic run_vec(input vec_t v, input int idx);
    logic got;
    int en_cnt, mwe_cnt;
    sb_t e;
    got = 1'b0; en_cnt = 0; mwe_cnt = 0;
    @(negedge clk);
    a_we = v.we; a_rd = v.rd; a_addr = v.addr; a_wdata = v.wdata;
    sb.push_back('{v.exp_wr, v.exp_data, v.exp_err});
    @(posedge clk); #1;
    a_we = 1'b0; a_rd = 1'b0; a_addr = 32'hffff_ffff; a_wdata = 32'h0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (a_mem_we) mwe_cnt++;
      if (a_mem_en) begin
        en_cnt++;
        check($sformatf("v%0d access_cycle", idx), 32'(c), 32'(A_WS + 1));
        check($sformatf("v%0d mem_addr", idx), {22'h0, a_mem_addr}, {22'h0, v.exp_maddr});
        check($sformatf("v%0d mem_we", idx), {31'h0, a_mem_we}, {31'h0, v.exp_wr});
        if (v.exp_wr) check($sformatf("v%0d mem_wdata", idx), a_mem_wdata, v.wdata);
      end
      if (a_wr_ack || a_rd_ack) begin
        got = 1'b1;
        e = sb.pop_front();
        check($sformatf("v%0d ack_latency", idx), 32'(c), 32'(A_WS + 2));
        check($sformatf("v%0d ack_type", idx), {30'h0, a_wr_ack, a_rd_ack},
              e.is_wr ? 32'd2 : 32'd1);
        if (e.is_wr) exp_wr_cnt++;
        else begin
          exp_rd_cnt++;
          last_rd = e.data;
          check($sformatf("v%0d rd_data", idx), a_data_in, e.data);
        end
`ifdef VP_MEM_BRIDGE_ERR_EN
        check($sformatf("v%0d err_irq", idx), {31'h0, a_err_irq}, {31'h0, e.err});
`endif
      end
    end
    check($sformatf("v%0d ack_seen", idx), {31'h0, got}, 32'd1);
    if (!got && sb.size() > 0) sb.delete(sb.size() - 1);
    check($sformatf("v%0d mem_en_pulses", idx), 32'(en_cnt), {31'h0, v.exp_en});
    check($sformatf("v%0d mem_we_pulses", idx), 32'(mwe_cnt), {31'h0, v.exp_wr & v.exp_en});
    @(negedge clk);
    check($sformatf("v%0d data_in_hold", idx), a_data_in, last_rd);
    check($sformatf("v%0d wr_count", idx), {16'h0, a_wr_count}, 32'(exp_wr_cnt));
    check($sformatf("v%0d rd_count", idx), {16'h0, a_rd_count}, 32'(exp_rd_cnt));
    @(negedge clk);
  endtask

  initial begin
    //          we    rd    addr           wdata          wr    en    maddr    data           err
    vecs[0] = '{1'b1, 1'b0, 32'ha000_0010, 32'h1234_5678, 1'b1, 1'b1, 10'h010, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'ha000_0010, 32'h0,         1'b0, 1'b1, 10'h010, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'ha000_0020, 32'hcafe_f00d, 1'b1, 1'b1, 10'h020, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'ha000_0020, 32'h0,         1'b0, 1'b1, 10'h020, 32'hcafe_f00d, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h5000_0000, 32'h0,         1'b0, 1'b0, 10'h000, OOS_EXP,       1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h5000_0010, 32'h1111_1111, 1'b1, 1'b0, 10'h010, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'ha000_0010, 32'h0,         1'b0, 1'b1, 10'h010, 32'h1234_5678, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'ha000_07ff, 32'h0bad_cafe, 1'b1, 1'b1, 10'h3ff, 32'h0,         1'b0};
    vecs[8] = '{1'b0, 1'b1, 32'ha123_43ff, 32'h0,         1'b0, 1'b1, 10'h3ff, 32'h0bad_cafe, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst data_in", a_data_in, 32'h0);
    check("rst acks_en_we", {28'h0, a_wr_ack, a_rd_ack, a_mem_en, a_mem_we}, 32'h0);
    check("rst mem_addr", {22'h0, a_mem_addr}, 32'h0);
    check("rst mem_wdata", a_mem_wdata, 32'h0);
    check("rst counts", {a_wr_count, a_rd_count}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Zero wait states: held read strobe completes every 4 cycles, ack 2 cycles after sampling
    b_addr = 32'ha000_0005; b_rd = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("b2b rd_ack c%0d", c), {31'h0, b_rd_ack}, (c % 4 == 2) ? 32'd1 : 32'd0);
      if (c % 4 == 2) check($sformatf("b2b data c%0d", c), b_data_in, 32'h5a5a_0005);
      if (c == 12) b_rd = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("b2b rd_count", {16'h0, b_rd_count}, 32'd3);
    check("b2b wr_count", {16'h0, b_wr_count}, 32'd0);

    // Reset during WAIT abandons the write; a read held through reset starts on the first edge after
    we_pulses = 0; acks_seen = 0;
    @(negedge clk);
    a_we = 1'b1; a_addr = 32'ha000_0010; a_wdata = 32'h9999_9999;
    @(posedge clk); #1;
    a_we = 1'b0;
    @(negedge clk);
    reset = 1'b1; a_rd = 1'b1;
    #1;
    check("abort counts", {a_wr_count, a_rd_count}, 32'h0);
    check("abort data_in", a_data_in, 32'h0);
    @(negedge clk);
    check("abort no_ack", 32'(acks_seen), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    a_rd = 1'b0;
    begin
      logic got;
      got = 1'b0;
      for (int c = 1; c <= 12 && !got; c++) begin
        @(negedge clk);
        if (a_rd_ack || a_wr_ack) begin
          got = 1'b1;
          check("post_rst latency", 32'(c), 32'(A_WS + 2));
          check("post_rst rd_ack", {30'h0, a_wr_ack, a_rd_ack}, 32'd1);
          check("post_rst data", a_data_in, 32'h1234_5678);
        end
      end
      check("post_rst ack_seen", {31'h0, got}, 32'd1);
    end
    @(negedge clk);
    check("post_rst no_mem_we", 32'(we_pulses), 32'd0);
    check("post_rst counts", {a_wr_count, a_rd_count}, 32'h0000_0001);

    // Saturating counter: 65537 increments end at 16'hffff
    check("sat start", {16'h0, c_count}, 32'h0);
    c_inc = 1'b1;
    repeat (65534) @(negedge clk);
    check("sat 65534", {16'h0, c_count}, 32'h0000_fffe);
    @(negedge clk);
    check("sat 65535", {16'h0, c_count}, 32'h0000_ffff);
    repeat (2) @(negedge clk);
    check("sat 65537", {16'h0, c_count}, 32'h0000_ffff);
    c_inc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
